// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, frame state encoding and data-length limits.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned MIN_DATA_BITS = 5;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_MARK = 2'b10;
    localparam logic [1:0] PAR_ODD  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak,
        StMark
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: counts 0..D-1 and strobes tick on the last count.
// A divisor of 0 is treated as 1, so tick is then high every clock.
module uart_baud_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic             restart,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d, last;

    always_comb begin
        last = (div == '0) ? '0 : div - 1'b1;
        tick = (cnt_q == last);
        // >= rather than == so a shrunken divisor can never strand the count above last
        if (restart || (cnt_q >= last)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: pops bytes from a registered-output FIFO and sends
// start, N data bits LSB-first, optional parity and 1 or 2 stop bits; also generates breaks.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned MAX_DATA_BITS = 8,
    parameter int unsigned DIV_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DIV_W-1:0]         cfg_baud_div,
    input  logic [3:0]               cfg_data_bits,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop2,
    input  logic                     break_req,
    input  logic                     fifo_empty,
    input  logic [MAX_DATA_BITS-1:0] fifo_rdata,
    output logic                     fifo_rd_en,
    output logic                     tx,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     baud_tick_o
);

    uart_state_e              state_q, state_d;
    logic [MAX_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    logic [3:0]               nbits_q, nbits_d;
    logic                     par_en_q, par_en_d;
    logic                     par_bit_q, par_bit_d;
    logic                     stop2_q, stop2_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic                     tx_q, tx_d;
    logic                     restart, tick;
    logic [3:0]               nbits_cfg;
    logic                     par_x, par_calc;

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .div     (div_q),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        if (cfg_data_bits < 4'(MIN_DATA_BITS)) begin
            nbits_cfg = 4'(MIN_DATA_BITS);
        end else if (32'(cfg_data_bits) > MAX_DATA_BITS) begin
            nbits_cfg = 4'(MAX_DATA_BITS);
        end else begin
            nbits_cfg = cfg_data_bits;
        end
    end

    // Parity covers only the bits that will actually be sent
    always_comb begin
        par_x = 1'b0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < int'(nbits_cfg)) begin
                par_x = par_x ^ fifo_rdata[i];
            end
        end
        case (cfg_parity)
            PAR_EVEN: par_calc = par_x;
            PAR_ODD:  par_calc = ~par_x;
            PAR_MARK: par_calc = 1'b1;
            default:  par_calc = 1'b0;
        endcase
    end

    assign fifo_rd_en  = (state_q == StIdle) && !fifo_empty && !break_req;
    assign busy        = (state_q != StIdle);
    assign tx          = tx_q;
    assign baud_tick_o = tick;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        div_d      = div_q;
        restart    = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            StIdle: begin
                if (break_req) begin
                    state_d = StBreak;
                    restart = 1'b1;
                    div_d   = cfg_baud_div;
                end else if (fifo_rd_en) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                shreg_d   = fifo_rdata;
                nbits_d   = nbits_cfg;
                par_en_d  = (cfg_parity != PAR_NONE);
                par_bit_d = par_calc;
                stop2_d   = cfg_stop2;
                div_d     = cfg_baud_div;
                bit_cnt_d = '0;
                restart   = 1'b1;
                state_d   = StStart;
            end
            StStart: begin
                if (tick) state_d = StData;
            end
            StData: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == nbits_q - 4'd1) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (tick) state_d = StStop;
            end
            StStop: begin
                if (tick) begin
                    // bit_cnt marks that the first of two stop bits has been sent
                    if (stop2_q && (bit_cnt_q == 4'd0)) begin
                        bit_cnt_d = 4'd1;
                    end else begin
                        bit_cnt_d  = '0;
                        frame_done = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end
            StBreak: begin
                // Restart so the mark period is a full bit regardless of break length
                if (!break_req) begin
                    state_d = StMark;
                    restart = 1'b1;
                end
            end
            StMark: begin
                if (tick) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        case (state_d)
            StStart, StBreak: tx_d = 1'b0;
            StData:           tx_d = shreg_d[0];
            StParity:         tx_d = par_bit_q;
            default:          tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            nbits_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            div_q     <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            nbits_q   <= nbits_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            div_q     <= div_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: a FIFO model feeds bytes, expected frames go to a scoreboard queue
// and are compared clock-by-clock against the serial line.
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_baud_div = 16'd4;
    logic [3:0]  cfg_data_bits = 4'd8;
    logic [1:0]  cfg_parity = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic        break_req = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata = 8'h00;
    logic        fifo_rd_en, tx, busy, frame_done, baud_tick_o;

    typedef struct {
        logic [15:0] line;
        int          nb;
        int          d;
    } exp_frame_t;

    typedef struct {
        logic [15:0] div;
        logic [3:0]  nb;
        logic [1:0]  par;
        logic        stop2;
        logic [7:0]  data;
        logic        exp_par;
        int          exp_clks;
    } vec_t;

    exp_frame_t exp_q[$];
    vec_t       vecs[8];
    logic [7:0] mem[64];
    int         push_cnt = 0;
    int         pop_cnt = 0;
    int         errors = 0;
    int         checks = 0;

    uart_tx_cfg #(
        .MAX_DATA_BITS (8),
        .DIV_W         (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_baud_div  (cfg_baud_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .break_req     (break_req),
        .fifo_empty    (fifo_empty),
        .fifo_rdata    (fifo_rdata),
        .fifo_rd_en    (fifo_rd_en),
        .tx            (tx),
        .busy          (busy),
        .frame_done    (frame_done),
        .baud_tick_o   (baud_tick_o)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (push_cnt == pop_cnt);

    always @(posedge clk) begin
        if (rst_n && fifo_rd_en) begin
            fifo_rdata <= mem[pop_cnt % 64];
            pop_cnt    <= pop_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[push_cnt % 64] = b;
        push_cnt++;
    endtask

    function automatic exp_frame_t make_frame(input logic [15:0] div, input logic [3:0] nb_cfg,
                                              input logic [1:0] par, input logic stop2,
                                              input logic [7:0] data, input logic par_bit);
        exp_frame_t f;
        int n, k;
        n = (nb_cfg < 4'd5) ? 5 : (nb_cfg > 4'd8) ? 8 : int'(nb_cfg);
        f.d = (div == 16'd0) ? 1 : int'(div);
        f.line = '1;
        k = 0;
        f.line[k] = 1'b0;
        k++;
        for (int i = 0; i < n; i++) begin
            f.line[k] = data[i];
            k++;
        end
        if (par != 2'b00) begin
            f.line[k] = par_bit;
            k++;
        end
        k += stop2 ? 2 : 1;
        f.nb = k;
        return f;
    endfunction

    // Waits for a start bit, pops the expected frame and samples the line every clock.
    task automatic check_frame(input string name, input int exp_clks, output int gap);
        exp_frame_t e;
        logic [127:0] act, expv;
        int len, fd_idx, fd_cnt, busy_bad, tick_cnt;
        gap = 0;
        @(negedge clk);
        while (tx !== 1'b0 && gap < 400) begin
            gap++;
            @(negedge clk);
        end
        if (gap >= 400) begin
            check({name, "_start_timeout"}, 128'(gap), 128'(0));
            return;
        end
        if (exp_q.size() == 0) begin
            check({name, "_scoreboard_empty"}, 128'(0), 128'(1));
            return;
        end
        e = exp_q.pop_front();
        len = e.nb * e.d;
        act = '0;
        expv = '0;
        fd_idx = -1;
        fd_cnt = 0;
        busy_bad = 0;
        tick_cnt = 0;
        for (int c = 0; c < len; c++) begin
            act[c] = tx;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_idx = c;
            end
            if (busy !== 1'b1) busy_bad++;
            if (baud_tick_o === 1'b1) tick_cnt++;
            if (c < len - 1) @(negedge clk);
        end
        for (int b = 0; b < e.nb; b++) begin
            for (int k = 0; k < e.d; k++) expv[b * e.d + k] = e.line[b];
        end
        check({name, "_line"}, act, expv);
        check({name, "_frame_clks"}, 128'((fd_cnt == 1) ? fd_idx + 1 : -1), 128'(exp_clks));
        check({name, "_busy"}, 128'(busy_bad), 128'(0));
        check({name, "_ticks"}, 128'(tick_cnt), 128'(e.nb));
    endtask

    task automatic count_while(input logic lvl, output int n);
        n = 0;
        @(negedge clk);
        while (tx === lvl && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) check("level_timeout", 128'(n), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int gap, rd0, h, l;
        exp_frame_t f;

        vecs[0] = '{16'd4, 4'd8,  2'b00, 1'b0, 8'hA5, 1'b0, 40};
        vecs[1] = '{16'd3, 4'd7,  2'b01, 1'b1, 8'h53, 1'b0, 33};
        vecs[2] = '{16'd2, 4'd5,  2'b11, 1'b0, 8'h3F, 1'b0, 16};
        vecs[3] = '{16'd2, 4'd5,  2'b10, 1'b0, 8'h3F, 1'b1, 16};
        vecs[4] = '{16'd0, 4'd8,  2'b11, 1'b0, 8'h81, 1'b1, 11};
        vecs[5] = '{16'd1, 4'd3,  2'b01, 1'b1, 8'hFF, 1'b1, 9};
        vecs[6] = '{16'd2, 4'd12, 2'b00, 1'b0, 8'h3C, 1'b0, 20};
        vecs[7] = '{16'd3, 4'd6,  2'b11, 1'b1, 8'h2A, 1'b0, 30};

        repeat (3) @(negedge clk);
        check("reset_tx", 128'(tx), 128'(1));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_rd_en", 128'(fifo_rd_en), 128'(0));
        check("reset_frame_done", 128'(frame_done), 128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            cfg_baud_div  = vecs[i].div;
            cfg_data_bits = vecs[i].nb;
            cfg_parity    = vecs[i].par;
            cfg_stop2     = vecs[i].stop2;
            exp_q.push_back(make_frame(vecs[i].div, vecs[i].nb, vecs[i].par, vecs[i].stop2,
                                       vecs[i].data, vecs[i].exp_par));
            rd0 = pop_cnt;
            push_byte(vecs[i].data);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_clks, gap);
            check($sformatf("vec%0d_latency", i), 128'(gap), 128'(1));
            check($sformatf("vec%0d_pops", i), 128'(pop_cnt - rd0), 128'(1));
            @(negedge clk);
            check($sformatf("vec%0d_idle_busy", i), 128'(busy), 128'(0));
            repeat (2) @(negedge clk);
        end

        // Back-to-back: three bytes, data length changed while the first is on the line
        cfg_baud_div  = 16'd2;
        cfg_data_bits = 4'd8;
        cfg_parity    = 2'b00;
        cfg_stop2     = 1'b0;
        exp_q.push_back(make_frame(16'd2, 4'd8, 2'b00, 1'b0, 8'h11, 1'b0));
        exp_q.push_back(make_frame(16'd2, 4'd5, 2'b00, 1'b0, 8'h22, 1'b0));
        exp_q.push_back(make_frame(16'd2, 4'd5, 2'b00, 1'b0, 8'h33, 1'b0));
        rd0 = pop_cnt;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        fork
            begin
                repeat (6) @(negedge clk);
                cfg_data_bits = 4'd5;
            end
        join_none
        check_frame("b2b0", 20, gap);
        check("b2b0_latency", 128'(gap), 128'(1));
        check_frame("b2b1", 14, gap);
        check("b2b1_gap", 128'(gap), 128'(2));
        check_frame("b2b2", 14, gap);
        check("b2b2_gap", 128'(gap), 128'(2));
        check("b2b_pops", 128'(pop_cnt - rd0), 128'(3));
        repeat (3) @(negedge clk);

        // Break raised mid-frame, a byte waiting in the FIFO during the break
        cfg_baud_div  = 16'd5;
        cfg_data_bits = 4'd8;
        exp_q.push_back(make_frame(16'd5, 4'd8, 2'b00, 1'b0, 8'h5A, 1'b0));
        push_byte(8'h5A);
        fork
            begin
                repeat (15) @(negedge clk);
                break_req = 1'b1;
                repeat (20) @(negedge clk);
                f = make_frame(16'd5, 4'd8, 2'b00, 1'b0, 8'hE7, 1'b0);
                exp_q.push_back(f);
                push_byte(8'hE7);
                repeat (30) @(negedge clk);
                break_req = 1'b0;
            end
        join_none
        check_frame("brk_frame", 50, gap);
        rd0 = pop_cnt;
        count_while(1'b1, h);
        check("brk_idle_before_low", 128'(h), 128'(1));
        check("brk_busy", 128'(busy), 128'(1));
        count_while(1'b0, l);
        check("brk_low_seen", 128'(l > 5), 128'(1));
        check("brk_no_pop", 128'(pop_cnt - rd0), 128'(0));
        check_frame("post_brk", 50, gap);
        check("brk_mark_high", 128'(gap + 1), 128'(7));
        check("post_brk_pops", 128'(pop_cnt - rd0), 128'(1));
        repeat (3) @(negedge clk);

        // Reset asserted while data bits are on the line
        cfg_baud_div = 16'd4;
        push_byte(8'h00);
        repeat (12) @(negedge clk);
        check("pre_rst_tx", 128'(tx), 128'(0));
        check("pre_rst_busy", 128'(busy), 128'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 128'(tx), 128'(1));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_frame_done", 128'(frame_done), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(make_frame(16'd4, 4'd8, 2'b00, 1'b0, 8'hC3, 1'b0));
        push_byte(8'hC3);
        check_frame("post_rst", 40, gap);
        check("post_rst_latency", 128'(gap), 128'(1));
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised next-generation UART transmitter. It pulls bytes from an upstream show-ahead-free (registered-output) FIFO and serialises them LSB-first. Data length, parity mode, stop bits and baud divisor are all selected at runtime, and the block can also generate a line break. It sits between the TX FIFO and the pad, and shares its baud/config register map with the receiver.

Parameters:
MAX_DATA_BITS, 8, largest supported data length; legal range 5..9.
DIV_W, 16, width of the baud divisor (clocks per bit).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_baud_div  in  DIV_W  clocks per bit period; 0 is treated as 1
cfg_data_bits  in  4  data length; values below 5 clamp to 5, values above MAX_DATA_BITS clamp to MAX_DATA_BITS
cfg_parity  in  2  00 none, 01 even, 10 mark (1), 11 odd
cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits
break_req  in  1  level request to hold the line low (break)
fifo_empty  in  1  TX FIFO empty
fifo_rdata  in  MAX_DATA_BITS  FIFO read data, valid the cycle after fifo_rd_en
fifo_rd_en  out  1  single-cycle FIFO pop
tx  out  1  serial line, registered, idle high
busy  out  1  high from LOAD until the frame returns to IDLE; also high during BREAK/MARK
frame_done  out  1  one-cycle pulse on the last clock of the final stop bit
baud_tick_o  out  1  bit-boundary strobe from the internal baud generator

Behaviour:
- Reset values (asynchronous, applied immediately even mid-frame): tx=1, fifo_rd_en=0, busy=0, frame_done=0, state=IDLE, counters=0. An in-flight byte is dropped and is not re-read.
- fifo_rd_en is combinational: (state==IDLE) && !fifo_empty && !break_req. It is never asserted in any other state.
- State machine:
  - IDLE:
    - break_req -> BREAK.
    - Otherwise, if a pop occurs -> LOAD.
    - break_req has priority over a non-empty FIFO.
  - LOAD (1 clk):
    - Latch fifo_rdata and snapshot all cfg_* inputs. Changes to cfg_* mid-frame are ignored until the next LOAD.
    - Restart the baud counter.
    - Compute parity over the cfg_data_bits LSBs only.
    - -> START.
  - START: tx=0 for D clocks (D = effective divisor) -> DATA.
  - DATA:
    - Shift out N bits LSB-first, D clocks each.
    - After bit N-1, go to PARITY if parity is enabled, else STOP.
  - PARITY: tx=parity bit for D clocks -> STOP.
  - STOP:
    - tx=1 for D clocks (2D clocks if cfg_stop2).
    - frame_done pulses on the final clock.
    - -> IDLE.
  - BREAK: tx=0 while break_req=1. On deassertion -> MARK.
  - MARK: tx=1 for D clocks -> IDLE. This state guarantees mark-after-break.
- A break_req raised mid-frame is held off until the frame completes; it is then honoured from IDLE.
- Baud generator:
  - Free-running counter 0..D-1, reset to 0 in LOAD and on entry to BREAK.
  - baud_tick_o is high when count==D-1.
  - All bit periods are exactly D clocks.
- Timing: tx registered. The line falls on the first clock edge after LOAD.
- Frame length in clocks: D*(1 + N + P + S), with P in {0,1} and S in {1,2}.
- Back-to-back frames: the IDLE and LOAD cycles add exactly 2 idle-high clocks between the end of one stop bit and the next start bit.
- D=1 is legal: each bit lasts 1 clock.
- Data bits above N in the latched word are ignored.

Decomposition:
- Package uart_pkg:
  - parity encoding constants PAR_NONE/PAR_EVEN/PAR_MARK/PAR_ODD
  - state encoding (IDLE, LOAD, START, DATA, PARITY, STOP, BREAK, MARK)
  - MIN_DATA_BITS=5
  - This package is shared with the receiver.
- Sub-module uart_baud_gen:
  - Inputs: clk, rst_n, div, restart.
  - Output: tick.
  - Reused by the receiver.

Test Plan:
- D=4, N=8, no parity, 1 stop, FIFO holds 0xA5:
  - fifo_rd_en pulses once.
  - tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 clks (40 clks total).
  - frame_done pulses on clk 40; busy drops afterwards.
- D=3, N=7, even parity, 2 stop, data 0x53 (four ones): parity bit=0; frame = 3*(1+7+1+2) = 33 clks.
- Odd parity, N=5, data 0x3F (only 0x1F transmitted, five ones): parity bit=0. Mark parity on the same data: parity bit=1.
- FIFO with 3 bytes, D=2: exactly 3 rd_en pulses; 2 idle-high clks between consecutive frames; cfg_data_bits changed mid-frame does not affect the current frame.
- break_req asserted mid-frame for 50 clks, D=5: the current frame completes intact; tx then goes low until break_req falls, then stays high for 5 clks; no FIFO pop during BREAK/MARK.
- rst_n asserted in the middle of DATA: tx=1 and busy=0 immediately. After release with FIFO non-empty, a new frame starts from LOAD with fresh data.
